// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, legal prescale values and the
// parity helper used by both uart_tx and uart_rx.
// Latency: n/a (types/constants only). Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, OUT} rx_state_t;

  localparam int unsigned PRESC_8   = 8;
  localparam int unsigned PRESC_16  = 16;
  localparam int unsigned PRESC_32  = 32;

  // Payload is zero-extended into this width before the parity reduction.
  localparam int unsigned PAR_W_MAX = 32;

  // typ = 0: even parity, typ = 1: odd parity.
  function automatic logic par_calc(input logic [PAR_W_MAX-1:0] data, input logic typ);
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling front end: 2-flop synchronizer, per-bit edge counter, 3-sample majority vote.
// Latency: 2 cycles synchronizer; vote valid at edge_cnt = presc/2+1. Backpressure: none.
// Ports: rx_i async line in; presc_i frame prescale; run_i counts while a frame is active;
//   ld1_i preloads edge_cnt = 1; rx_s_o synced line; sampled_bit_o voted bit (live on
//   sample_done_o, held afterwards); bit_done_o last cycle of a bit.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic [PRESCALE_W-1:0] presc_i,
  input  logic                  run_i,
  input  logic                  ld1_i,
  output logic                  rx_s_o,
  output logic                  sampled_bit_o,
  output logic                  bit_done_o,
  output logic                  sample_done_o
);

  logic                  sync1_q, sync2_q;
  logic                  s0_q, s1_q, bit_q;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] half;
  logic                  vote;

  assign half          = presc_i >> 1;
  assign rx_s_o        = sync2_q;
  assign bit_done_o    = (edge_cnt_q == presc_i - PRESCALE_W'(1));
  assign sample_done_o = (edge_cnt_q == half + PRESCALE_W'(1));

  // Third sample is the live synchronized line, so the vote resolves in the
  // same cycle as the last sample and the FSM can act on it immediately.
  assign vote          = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign sampled_bit_o = sample_done_o ? vote : bit_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    if (ld1_i) begin
      edge_cnt_d = PRESCALE_W'(1);
    end else if (!run_i || bit_done_o) begin
      edge_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_cnt_q <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      sync1_q    <= rx_i;
      sync2_q    <= sync1_q;
      edge_cnt_q <= edge_cnt_d;
      if (edge_cnt_q == half - PRESCALE_W'(1)) s0_q <= sync2_q;
      if (edge_cnt_q == half)                  s1_q <= sync2_q;
      if (sample_done_o)                       bit_q <= vote;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled, majority-voted, optional parity, stop-bit check.
// Latency: 1 cycle from last stop-bit sample to the Data_Valid/error strobe. Backpressure: none.
// Ports: CLK/RST (async active-low); RX_IN serial line; PAR_EN/PAR_TYP/Prescale frame config,
//   latched at frame start; P_DATA last good payload; Data_Valid/Parity_Error/Stop_Error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  armed_q, armed_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] presc_sel;
  logic                  rx_s, sampled_bit, bit_done, sample_done;
  logic                  run, ld1;

  // Unsupported prescales fall back to 16 so the edge counter always wraps sanely.
  assign presc_sel = (Prescale == PRESCALE_W'(PRESC_8)  ||
                      Prescale == PRESCALE_W'(PRESC_16) ||
                      Prescale == PRESCALE_W'(PRESC_32)) ? Prescale : PRESCALE_W'(PRESC_16);

  assign run = (state_q == START) || (state_q == DATA) ||
               (state_q == PARITY) || (state_q == STOP);

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk_i         (CLK),
    .rst_ni        (RST),
    .rx_i          (RX_IN),
    .presc_i       (presc_q),
    .run_i         (run),
    .ld1_i         (ld1),
    .rx_s_o        (rx_s),
    .sampled_bit_o (sampled_bit),
    .bit_done_o    (bit_done),
    .sample_done_o (sample_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      p_data_q  <= '0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      armed_q   <= 1'b1;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= PRESCALE_W'(PRESC_8);
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      armed_q   <= armed_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      presc_q   <= presc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    armed_d   = armed_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;
    ld1       = 1'b0;
    case (state_q)
      IDLE: begin
        // After a break the line must be seen high before a new start edge counts.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          presc_d   = presc_sel;
        end
      end
      START: begin
        if (bit_done) begin
          if (!sampled_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_err_d = (sampled_bit != par_calc(PAR_W_MAX'(shift_q), par_typ_q));
          state_d   = STOP;
        end
      end
      STOP: begin
        // Leave mid stop bit so a following start edge is not missed.
        if (sample_done) begin
          stp_err_d = !sampled_bit;
          state_d   = OUT;
          if (sampled_bit && !par_err_q) p_data_d = shift_q;
        end
      end
      OUT: begin
        if (!rx_s && !stp_err_q) begin
          state_d   = START;
          ld1       = 1'b1;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          presc_d   = presc_sel;
        end else begin
          state_d = IDLE;
          armed_d = !stp_err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Data_Valid   = 1'b0;
    Parity_Error = 1'b0;
    Stop_Error   = 1'b0;
    if (state_q == OUT) begin
      Data_Valid   = !par_err_q && !stp_err_q;
      Parity_Error = par_err_q;
      Stop_Error   = stp_err_q;
    end
  end

  assign P_DATA = p_data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit-serially, the expected strobe
// for each frame is queued when it is sent and checked when the DUT strobes.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       Data_Valid, Parity_Error, Stop_Error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       dv;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;
  logic       pbit;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_par(input logic [7:0] d, input logic odd);
    return (($countones(d) % 2) == 1) ^ odd;
  endfunction

  // Queue the strobe a frame should produce; P_DATA only advances on a clean frame.
  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic se);
    exp_t e;
    if (!pe && !se) last_good = d;
    e.data = last_good;
    e.dv   = !pe && !se;
    e.pe   = pe;
    e.se   = se;
    sb_q.push_back(e);
  endtask

  // One bit period; optionally flip the line for one cycle on the middle sample.
  task automatic drive_bit(input logic b, input logic glitch);
    int p;
    p = int'(Prescale);
    for (int i = 0; i < p; i++) begin
      @(negedge CLK);
      RX_IN = (glitch && i == p / 2 + 1) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                            input logic stop_bit, input int glitch_idx);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_idx == i);
    if (has_par) drive_bit(par_bit, 1'b0);
    drive_bit(stop_bit, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge CLK);
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  always @(negedge CLK) begin
    if (Data_Valid || Parity_Error || Stop_Error) begin
      check("strobe_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("data_valid",   32'(Data_Valid),   32'(mon_e.dv));
        check("parity_error", 32'(Parity_Error), 32'(mon_e.pe));
        check("stop_error",   32'(Stop_Error),   32'(mon_e.se));
        check("p_data",       32'(P_DATA),       32'(mon_e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_data_valid",   32'(Data_Valid),   32'd0);
    check("rst_parity_error", 32'(Parity_Error), 32'd0);
    check("rst_stop_error",   32'(Stop_Error),   32'd0);
    check("rst_p_data",       32'(P_DATA),       32'd0);
    RST = 1'b1;
    idle(10);

    // Prescale 8, no parity
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    idle(5);
    drain("drain_a5");

    // Prescale 16, even parity: good then bad parity bit
    Prescale = 6'd16;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b0;
    pbit = ref_par(8'h3C, 1'b0);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, pbit, 1'b1, -1);
    idle(5);
    drain("drain_3c_good");
    expect_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, ~pbit, 1'b1, -1);
    idle(5);
    drain("drain_3c_bad_par");
    check("p_data_hold_after_par_err", 32'(P_DATA), 32'h3C);

    // Prescale 32, odd parity, back-to-back frames with no idle gap
    Prescale = 6'd32;
    PAR_TYP  = 1'b1;
    expect_frame(8'h01, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, ref_par(8'h01, 1'b1), 1'b1, -1);
    send_frame(8'hFF, 1'b1, ref_par(8'hFF, 1'b1), 1'b1, -1);
    idle(10);
    drain("drain_b2b");

    // Stop bit low, then line held low (break): one Stop_Error, nothing more
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    expect_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 480; i++) begin
      @(negedge CLK);
      RX_IN = 1'b0;
    end
    drain("drain_break");
    check("p_data_hold_after_break", 32'(P_DATA), 32'hFF);
    idle(40);
    expect_frame(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1);
    idle(5);
    drain("drain_after_break");

    // Three-cycle start glitch must be rejected silently
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      RX_IN = 1'b0;
    end
    idle(200);
    check("glitch_no_strobe", 32'(sb_q.size()), 32'd0);

    // One-cycle pulse on the middle sample of data bit 1 is outvoted
    expect_frame(8'h0F, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1);
    idle(5);
    drain("drain_0f_glitch");

    // Reset in the middle of the data bits
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("midrst_p_data",       32'(P_DATA),       32'd0);
    check("midrst_data_valid",   32'(Data_Valid),   32'd0);
    check("midrst_parity_error", 32'(Parity_Error), 32'd0);
    check("midrst_stop_error",   32'(Stop_Error),   32'd0);
    last_good = 8'h00;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(20);
    expect_frame(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    drain("drain_96");
    check("final_p_data", 32'(P_DATA), 32'h96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver. It is the receive-side counterpart of the existing uart_tx and lives alongside it under the uart_tx_top environment.
- Oversamples RX_IN with a runtime prescale and majority-votes each bit.
- Supports optional even/odd parity and checks the stop bit.
- Presents each received frame as a one-cycle P_DATA/Data_Valid strobe with error flags.

Parameters:
- DATA_WIDTH, 8, payload bits per frame, LSB first.
- PRESCALE_W, 6, width of the Prescale input.

Ports:
- CLK  input  1  system clock, 100 MHz in the top-level bench.
- RST  input  1  reset, asynchronous, active-low.
- RX_IN  input  1  serial line, idles high; asynchronous to CLK.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_W  CLK cycles per bit; legal values 8, 16, 32.
- P_DATA  output  DATA_WIDTH  received payload.
- Data_Valid  output  1  one-cycle strobe when a frame is accepted.
- Parity_Error  output  1  one-cycle strobe when parity check fails.
- Stop_Error  output  1  one-cycle strobe when stop bit is sampled low.

Behaviour:
- Reset (RST low, async): all outputs 0, P_DATA = 0. State = IDLE, counters = 0, synchronizer flops = 1.
- Input synchronization: RX_IN passes through a 2-flop synchronizer (rx_s) before any use; this adds 2 cycles of latency.
- Bit timing:
  - edge_cnt counts 0..Prescale-1 within each bit; bit_cnt indexes bits within the frame.
  - Sample points are edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - Bit value is the majority of the three samples, latched at edge_cnt = Prescale/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, OUT.
- IDLE: rx_s = 0 moves to START with edge_cnt = 0.
- START: at the end of the bit (edge_cnt = Prescale-1):
  - voted 0 -> DATA;
  - voted 1 -> IDLE (glitch rejection); no flags raised.
- DATA: shift voted bits LSB-first into a shift register. After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
- PARITY:
  - Expected parity = XOR of payload, inverted when PAR_TYP = 1.
  - On mismatch, set an internal par_err flag. Continue to STOP regardless.
- STOP:
  - Vote stop bit; voted 0 sets an internal stp_err.
  - At edge_cnt = Prescale/2+1 (not the bit end), go to OUT. This allows back-to-back frames with no idle gap.
- OUT (exactly one cycle):
  - Data_Valid = 1 only if neither error is set; P_DATA is updated only when Data_Valid = 1.
  - Parity_Error = par_err; Stop_Error = stp_err.
  - Then go to IDLE. If rx_s = 0 in this cycle, go directly to START with edge_cnt = 1.
- P_DATA holds its last valid value between frames.
- PAR_EN, PAR_TYP and Prescale are sampled at the IDLE->START transition and held for the whole frame; changes mid-frame have no effect.
- Illegal Prescale (any value other than 8/16/32): behaviour unspecified; the bench must not drive it.
- Reset mid-frame: aborts immediately to IDLE; no strobe is issued.
- Break condition (line held low): the frame ends with Stop_Error = 1. The receiver then re-enters START only after rx_s has been seen high at least once in IDLE.
- Frame latency: last sample of the stop bit to the Data_Valid strobe is 1 cycle.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP, OUT};
  - the legal prescale constants PRESC_8, PRESC_16, PRESC_32;
  - a function par_calc(data, typ), shared with uart_tx.
- Sub-module uart_rx_sampler: owns the 2-flop synchronizer, edge_cnt and the 3-sample majority vote. It outputs rx_s, sampled_bit, bit_done and sample_done to the uart_rx FSM.

Test Plan:
- Prescale = 8, PAR_EN = 0, send 0xA5 with a valid stop bit -> Data_Valid pulses 1 cycle, P_DATA = 0xA5, Parity_Error = Stop_Error = 0.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0:
  - send 0x3C with parity bit 0 -> Data_Valid, P_DATA = 0x3C;
  - resend with parity bit 1 -> Parity_Error = 1, Data_Valid = 0, P_DATA stays 0x3C.
- Prescale = 32, PAR_TYP = 1: send 0x01 then 0xFF back-to-back with zero idle gap -> two Data_Valid strobes, P_DATA = 0x01 then 0xFF, no errors.
- Stop bit driven low on 0x55 -> Stop_Error = 1, Data_Valid = 0. Hold the line low afterwards -> no further strobes until the line returns high.
- Start-bit glitch: low for 3 cycles at Prescale = 16 -> FSM returns to IDLE, no strobes. Then a 1-cycle low pulse injected at a mid-data sample point of 0x0F -> majority vote still yields P_DATA = 0x0F.
- RST asserted low mid-DATA of a frame -> outputs immediately 0, no strobe. After release, a clean 0x96 frame is received correctly.
